// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: FSM states,
// offset width and OPB (ascending, MSB-first) to word lane mapping.
package opb_regbank_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   typedef logic [31:0] word_t;

   // Wide enough for any legal C_NUM_REGS (1..64) plus the commit offset.
   localparam int unsigned MAX_NUM_REGS = 64;
   localparam int unsigned OFF_W        = $clog2(MAX_NUM_REGS + 1);

   // OPB bit k is word bit 31-k; the ascending range already carries that order.
   function automatic word_t opb_to_word(input logic [0:31] v);
      return v;
   endfunction

   function automatic logic [0:31] word_to_opb(input word_t w);
      return w;
   endfunction

   // BE[0] covers word bits [31:24], BE[3] covers [7:0].
   function automatic word_t be_to_mask(input logic [0:3] be);
      return {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
   endfunction

endpackage

// File: rtl/opb_regbank_decode.sv
// Combinational window decode: hit, word offset (saturated past the commit
// offset so it can never alias it) and user-register in-range flag.
module opb_regbank_decode
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'hFFFF_FFFF,
   parameter logic [31:0] C_HIGHADDR = 32'h0000_0000,
   parameter int unsigned C_NUM_REGS = 8
)(
   input  logic [31:0]      addr_i,
   output logic             hit_o,
   output logic [OFF_W-1:0] off_o,
   output logic             in_range_o
);

   logic [29:0] woff;

   always_comb begin
      hit_o      = (addr_i >= C_BASEADDR) && (addr_i <= C_HIGHADDR);
      woff       = 30'((addr_i - C_BASEADDR) >> 2);
      in_range_o = hit_o && (woff < 30'(C_NUM_REGS));
      off_o      = (woff <= 30'(C_NUM_REGS)) ? woff[OFF_W-1:0] : '1;
   end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS byte-writable control registers to user logic.
// Define OPB_REGBANK_SHADOW_EN for shadowed writes with an atomic commit register.
module opb_register_bank_ppc2simulink
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int unsigned C_NUM_REGS   = 8,
   parameter logic [31:0] C_RESET_VAL  = 32'h0,
   parameter string       C_FAMILY     = "virtex5"
)(
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_xferAck,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   output logic [32*C_NUM_REGS-1:0]  user_data_out,
   output logic [C_NUM_REGS-1:0]     user_wr_strb
);

   localparam int unsigned IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

   state_t                 state_q;
   word_t                  out_q [C_NUM_REGS];
   logic                   ack_q;
   word_t                  rdata_q, rdata_d;
   logic [C_NUM_REGS-1:0]  strb_q;
   logic                   wr_q;
   logic [IDX_W-1:0]       idx_q;
   word_t                  wdata_q, wmask_q;

   logic                   dec_hit, dec_in_range;
   logic [OFF_W-1:0]       dec_off;
   logic                   unused_seq;

`ifdef OPB_REGBANK_SHADOW_EN
   localparam logic [OFF_W-1:0] COMMIT_OFF = OFF_W'(C_NUM_REGS);
   word_t                  shadow_q [C_NUM_REGS];
   logic                   commit_q;
`endif

   assign unused_seq = OPB_seqAddr;

   opb_regbank_decode #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR),
      .C_NUM_REGS (C_NUM_REGS)
   ) u_decode (
      .addr_i     (opb_to_word(OPB_ABus)),
      .hit_o      (dec_hit),
      .off_o      (dec_off),
      .in_range_o (dec_in_range)
   );

   always_comb begin
      rdata_d = '0;
      if (OPB_RNW && dec_in_range) begin
`ifdef OPB_REGBANK_SHADOW_EN
         rdata_d = shadow_q[dec_off[IDX_W-1:0]];
`else
         rdata_d = out_q[dec_off[IDX_W-1:0]];
`endif
      end
   end

   // Request is captured on the IDLE->ACK edge; the write lands on the edge ending ACK.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         strb_q  <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         for (int unsigned i = 0; i < C_NUM_REGS; i++) out_q[i] <= C_RESET_VAL;
`ifdef OPB_REGBANK_SHADOW_EN
         commit_q <= 1'b0;
         for (int unsigned i = 0; i < C_NUM_REGS; i++) shadow_q[i] <= C_RESET_VAL;
`endif
      end else begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
         strb_q  <= '0;
         unique case (state_q)
            IDLE: begin
               if (OPB_select && dec_hit) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
                  rdata_q <= rdata_d;
                  wr_q    <= !OPB_RNW && dec_in_range && (OPB_BE != '0);
                  idx_q   <= dec_off[IDX_W-1:0];
                  wdata_q <= opb_to_word(OPB_DBus);
                  wmask_q <= be_to_mask(OPB_BE);
`ifdef OPB_REGBANK_SHADOW_EN
                  commit_q <= !OPB_RNW && (dec_off == COMMIT_OFF);
`endif
               end
            end
            ACK: begin
               state_q <= IDLE;
`ifdef OPB_REGBANK_SHADOW_EN
               if (wr_q)
                  shadow_q[idx_q] <= (shadow_q[idx_q] & ~wmask_q) | (wdata_q & wmask_q);
               if (commit_q) begin
                  for (int unsigned i = 0; i < C_NUM_REGS; i++) out_q[i] <= shadow_q[i];
                  strb_q <= '1;
               end
`else
               if (wr_q) begin
                  out_q[idx_q]  <= (out_q[idx_q] & ~wmask_q) | (wdata_q & wmask_q);
                  strb_q[idx_q] <= 1'b1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      user_data_out = '0;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) user_data_out[32*i +: 32] = out_q[i];
   end

   assign user_wr_strb = strb_q;
   assign Sl_xferAck   = ack_q;
   assign Sl_DBus      = word_to_opb(rdata_q);
   assign Sl_errAck    = 1'b0;
   assign Sl_retry     = 1'b0;
   assign Sl_toutSup   = 1'b0;

endmodule
